uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Frame geometry and state encoding live here so the bench and RTL agree.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 433;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake into the UART transmitter (valid/ready).
interface uart_tx_if
  import uart_pkg::*;
();

  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
// A push while full or a pop while empty is ignored.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a small FIFO; the serial line is a flop that
// lags the state register by one cycle, so every bit still lasts CLKS_PER_BIT cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave tx_if,
  output logic     uart_txd,
  output logic     busy
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned     IdxW    = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 ready_q, ready_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 cnt_last;

  // ready_q holds in_ready low until the first edge after reset release.
  assign ready_d        = 1'b1;
  assign tx_if.in_ready = ready_q & ~fifo_full;
  assign fifo_push      = tx_if.in_valid & tx_if.in_ready;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (tx_if.in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx_q == IdxLast) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit so frames stay gap-free.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[bit_idx_q];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
    end
  end

  assign uart_txd = txd_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model (queue + cycle-in-frame counter) predicts
// uart_txd/busy/in_ready every cycle; a line receiver pins decoded bytes to literals.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned C     = 4;
  localparam int unsigned D     = 4;
  localparam int unsigned FRAME = 10 * C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic uart_txd, busy;

  uart_tx_if tx_if ();

  uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_if    (tx_if),
    .uart_txd (uart_txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: a frame is either idle or at cycle m_t (0..FRAME-1) of byte m_cur.
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_cur    = 8'h00;
  logic [7:0] m_q[$];
  bit         m_rdy    = 1'b0;
  bit         exp_txd  = 1'b1;
  bit         last_acc = 1'b0;
  logic [7:0] acc_log[$];

  // Receiver decoding the DUT line.
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];
  int         rx_starts[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit line_level(input bit act, input int t, input logic [7:0] cur);
    int b;
    if (!act) return 1'b1;
    b = t / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  task automatic rx_update();
    int idx;
    if (!rst_n) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (uart_txd == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= C + C/2 && rx_cnt < 9*C + C/2 && (rx_cnt - C/2) % C == 0) begin
        idx = (rx_cnt - C/2) / C - 1;
        rx_byte[idx] = uart_txd;
      end
      if (rx_cnt == 9*C + C/2) begin
        chk("rx_stop_bit", uart_txd, 1);
        rx_q.push_back(rx_byte);
        rx_busy = 1'b0;
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic cycle();
    bit acc;
    bit nxt_txd;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_q.delete();
      m_rdy    = 1'b0;
      exp_txd  = 1'b1;
      last_acc = 1'b0;
    end else begin
      acc     = tx_if.in_valid && m_rdy && (m_q.size() < D);
      nxt_txd = line_level(m_active, m_t, m_cur);
      if (!m_active) begin
        if (m_q.size() > 0) begin
          m_cur    = m_q.pop_front();
          m_active = 1'b1;
          m_t      = 0;
        end
      end else if (m_t == FRAME - 1) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_t   = 0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_t++;
      end
      if (acc) begin
        m_q.push_back(tx_if.in_data);
        acc_log.push_back(tx_if.in_data);
      end
      last_acc = acc;
      m_rdy    = 1'b1;
      exp_txd  = nxt_txd;
    end
    #1;
    chk("uart_txd", uart_txd, exp_txd);
    chk("busy", busy, m_active || (m_q.size() > 0));
    chk("in_ready", tx_if.in_ready, m_rdy && (m_q.size() < D));
    rx_update();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_active || m_q.size() > 0) && n < 3000) begin
      cycle();
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
    repeat (4) cycle();
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_starts.delete();
    acc_log.delete();
  endtask

  // Received bytes must be first, first+step, ... (mod 256).
  task automatic chk_rx(input string name, input int n, input logic [7:0] first,
                        input int step);
    logic [7:0] e;
    chk({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      e = 8'(int'(first) + i * step);
      chk({name, "_byte"}, rx_q[i], e);
    end
  endtask

  initial begin
    logic [39:0] wave;
    int          n0;
    int          n;
    int          acc_in;
    int          starts_before;
    bit          seen_low;
    logic [7:0]  nxt;

    tx_if.in_valid = 1'b0;
    tx_if.in_data  = 8'h00;

    // Reset values, then in_ready rises on the first edge after release.
    repeat (3) cycle();
    chk("reset_txd", uart_txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", tx_if.in_ready, 0);
    rst_n = 1'b1;
    cycle();
    chk("ready_after_release", tx_if.in_ready, 1);
    repeat (2) cycle();

    // Single byte 0xA5: exact line waveform and busy drop.
    clear_logs();
    tx_if.in_valid = 1'b1;
    tx_if.in_data  = 8'hA5;
    cycle();
    tx_if.in_valid = 1'b0;
    tx_if.in_data  = 8'h00;
    cycle();
    for (int i = 0; i < 40; i++) begin
      cycle();
      wave[39-i] = uart_txd;
      if (i == 38) chk("a5_busy_in_stop", busy, 1);
    end
    chk("a5_wave", wave, 40'h0F0F00F0FF);
    chk("a5_busy_drop", busy, 0);
    drain();
    chk_rx("a5_rx", 1, 8'hA5, 0);

    // Latency from IDLE; in_data changes right after acceptance.
    clear_logs();
    tx_if.in_valid = 1'b1;
    tx_if.in_data  = 8'h55;
    cycle();
    n0             = cyc;
    tx_if.in_valid = 1'b0;
    tx_if.in_data  = 8'($urandom);
    n = 0;
    do begin
      cycle();
      n++;
    end while (uart_txd != 1'b0 && n < 20);
    chk("latency_edges", cyc - n0, 2);
    drain();
    chk_rx("latency_rx", 1, 8'h55, 0);

    // Back-to-back 0x00, 0xFF: frames exactly FRAME cycles apart.
    clear_logs();
    tx_if.in_valid = 1'b1;
    tx_if.in_data  = 8'h00;
    cycle();
    tx_if.in_data  = 8'hFF;
    cycle();
    tx_if.in_valid = 1'b0;
    drain();
    chk("b2b_frames", rx_starts.size(), 2);
    if (rx_starts.size() == 2) chk("b2b_spacing", rx_starts[1] - rx_starts[0], 40);
    chk_rx("b2b_rx", 2, 8'h00, 255);

    // Full FIFO: hold valid with 0x01..0x06.
    clear_logs();
    nxt            = 8'h01;
    acc_in         = 0;
    seen_low       = 1'b0;
    n              = 0;
    tx_if.in_valid = 1'b1;
    tx_if.in_data  = nxt;
    while (nxt <= 8'h06 && n < 400) begin
      cycle();
      n++;
      if (last_acc) begin
        acc_in++;
        nxt           = nxt + 8'h01;
        tx_if.in_data = nxt;
      end
      if (!seen_low && !tx_if.in_ready) begin
        seen_low = 1'b1;
        chk("full_accepted_at_stall", acc_in, 5);
      end
      if (nxt == 8'h07) tx_if.in_valid = 1'b0;
    end
    tx_if.in_valid = 1'b0;
    chk("full_in_time", n < 400, 1);
    chk("full_stalled", seen_low, 1);
    drain();
    chk_rx("full_rx", 6, 8'h01, 1);

    // Push at 3/4 occupancy on the final STOP cycle.
    clear_logs();
    tx_if.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tx_if.in_data = 8'(i * 17);
      cycle();
    end
    tx_if.in_valid = 1'b0;
    n = 0;
    while (!(m_active && m_t == FRAME - 1 && m_q.size() == 3) && n < 100) begin
      cycle();
      n++;
    end
    chk("overlap_found", n < 100, 1);
    tx_if.in_valid = 1'b1;
    tx_if.in_data  = 8'h55;
    cycle();
    tx_if.in_valid = 1'b0;
    chk("overlap_accepted", last_acc, 1);
    chk("overlap_occupancy", m_q.size(), 3);
    chk("overlap_ready", tx_if.in_ready, 1);
    drain();
    chk_rx("overlap_rx", 5, 8'h11, 17);

    // Reset during DATA bit 3 of 0x3C with two bytes queued.
    clear_logs();
    tx_if.in_valid = 1'b1;
    tx_if.in_data  = 8'h3C;
    cycle();
    tx_if.in_data  = 8'h01;
    cycle();
    tx_if.in_data  = 8'h02;
    cycle();
    tx_if.in_valid = 1'b0;
    repeat (17) cycle();
    chk("rst_mid_in_bit3", m_active && (m_t / C == 4), 1);
    starts_before = rx_starts.size();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", uart_txd, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", tx_if.in_ready, 0);
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (100) cycle();
    chk("rst_no_new_frames", rx_starts.size(), starts_before);
    chk("rst_no_rx_bytes", rx_q.size(), 0);

    // Randomized traffic against the model.
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      tx_if.in_valid = ($urandom_range(0, 3) == 0);
      tx_if.in_data  = 8'($urandom);
      cycle();
    end
    tx_if.in_valid = 1'b0;
    drain();
    chk("rand_rx_count", rx_q.size(), acc_log.size());
    for (int i = 0; i < rx_q.size() && i < acc_log.size(); i++) begin
      chk("rand_rx_byte", rx_q[i], acc_log[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
